// File: rtl/regfile_pkg.sv
// Shared write-size codes and clear-FSM state encoding for the multi-port register file.
package regfile_pkg;

    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_merge.sv
// Merges a partial (byte/half) or full write into the existing register value.
module regfile_merge
    import regfile_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] old_val,
    input  logic [XLEN-1:0] wr_data,
    input  logic [1:0]      wr_size,
    output logic [XLEN-1:0] merged
);

    logic [XLEN-1:0] half_val;

    // At XLEN == 16 a half write already covers the whole register.
    if (XLEN > 16) begin : g_half_merge
        assign half_val = {old_val[XLEN-1:16], wr_data[15:0]};
    end else begin : g_half_full
        assign half_val = wr_data;
    end

    always_comb begin
        merged = wr_data;
        case (wr_size)
            SZ_HALF: merged = half_val;
            SZ_BYTE: merged = {old_val[XLEN-1:8], wr_data[7:0]};
            default: merged = wr_data;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with hardware-zero r0, partial-write merge,
// optional write-to-read bypass and a sequential clear FSM.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int AW     = $clog2(NREGS),
    parameter int NRD    = 2,
    parameter int BYPASS = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic [1:0]          wr_size,
    input  logic                rd_en,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic                clr_req,
    output logic                busy
);

    localparam logic [AW:0]   NREGS_W  = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
    localparam logic [AW-1:0] FIRST_IDX = AW'(1);

    logic [XLEN-1:0]     mem [1:NREGS-1];
    state_e              state_q, state_d;
    logic [AW-1:0]       clr_idx_q, clr_idx_d;
    logic [NRD*XLEN-1:0] rd_data_q, rd_data_d;
    logic [NRD*XLEN-1:0] rd_val;
    logic                idle;
    logic                wr_ok;
    logic [XLEN-1:0]     wr_old;
    logic [XLEN-1:0]     merged;

    assign wr_ok  = idle && wr_en && (wr_addr != '0) && ({1'b0, wr_addr} < NREGS_W);
    assign wr_old = wr_ok ? mem[wr_addr] : '0;

    regfile_merge #(.XLEN(XLEN)) u_merge (
        .old_val (wr_old),
        .wr_data (wr_data),
        .wr_size (wr_size),
        .merged  (merged)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= FIRST_IDX;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + FIRST_IDX;
                if (clr_idx_q == LAST_IDX) begin
                    state_d   = ST_IDLE;
                    clr_idx_d = FIRST_IDX;
                end
            end
            default: begin
                if (clr_req) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = FIRST_IDX;
                end
            end
        endcase
    end

    always_comb begin
        busy = (state_q == ST_CLEAR);
        idle = (state_q == ST_IDLE);
    end

    // Storage has no reset; the clear FSM zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= merged;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   idx;
        logic [XLEN-1:0] val;

        assign idx = rd_addr[p*AW +: AW];

        always_comb begin
            val = '0;
            if ((idx != '0) && ({1'b0, idx} < NREGS_W)) begin
                val = mem[idx];
            end
            if ((BYPASS != 0) && wr_ok && (idx == wr_addr)) begin
                val = merged;
            end
        end

        assign rd_val[p*XLEN +: XLEN] = val;
    end

    always_comb begin
        rd_data_d = rd_data_q;
        if (idle && rd_en) begin
            rd_data_d = rd_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench: two instances (32 regs with bypass, 24 regs without) share one stimulus stream.
module tb_regfile_mp;
    import regfile_pkg::*;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] b0;
        logic [31:0] b1;
        int          id;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_size;
    logic        rd_en;
    logic [9:0]  rd_addr;
    logic        clr_req;
    logic [63:0] rd_data_a, rd_data_b;
    logic        busy_a, busy_b;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   vec_id = 0;
    int   cnt_a, cnt_b;

    regfile_mp #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_size(wr_size), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .clr_req(clr_req), .busy(busy_a)
    );

    regfile_mp #(.XLEN(32), .NREGS(24), .NRD(2), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_size(wr_size), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .clr_req(clr_req), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                  input logic [1:0] ws, input logic re,
                                  input logic [4:0] ra0, input logic [4:0] ra1,
                                  input logic [31:0] ea0, input logic [31:0] ea1,
                                  input logic [31:0] eb0, input logic [31:0] eb1);
        @(negedge clk);
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        wr_size = ws;
        rd_en   = re;
        rd_addr = {ra1, ra0};
        clr_req = 1'b0;
        if (re) begin
            exp_t e;
            e.a0 = ea0; e.a1 = ea1; e.b0 = eb0; e.b1 = eb1; e.id = vec_id;
            vec_id++;
            sb_q.push_back(e);
        end
    endtask

    task automatic wr_word(input logic [4:0] wa, input logic [31:0] wd);
        apply_stimulus(1'b1, wa, wd, SZ_WORD, 1'b0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    task automatic rd_pair(input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic [31:0] ea0, input logic [31:0] ea1,
                           input logic [31:0] eb0, input logic [31:0] eb1);
        apply_stimulus(1'b0, 5'd0, 32'd0, SZ_WORD, 1'b1, ra0, ra1, ea0, ea1, eb0, eb1);
    endtask

    task automatic idle_cycle();
        apply_stimulus(1'b0, 5'd0, 32'd0, SZ_WORD, 1'b0, 5'd0, 5'd0, 0, 0, 0, 0);
    endtask

    // Called at a negedge; counts cycles each instance stays busy, optionally hammering writes.
    task automatic count_busy(input logic drive_wr, output int ca, output int cb);
        ca = 0;
        cb = 0;
        for (int i = 0; i < 200; i++) begin
            if (busy_a) ca++;
            if (busy_b) cb++;
            if (!busy_a && !busy_b) break;
            rd_en   = 1'b0;
            wr_en   = drive_wr && busy_a && busy_b;
            wr_addr = 5'(i);
            wr_data = 32'hFFFF_FFFF;
            wr_size = SZ_WORD;
            clr_req = drive_wr && busy_a && busy_b && (i == 20);
            @(negedge clk);
        end
        wr_en   = 1'b0;
        clr_req = 1'b0;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n && rd_en && !busy_a && !busy_b) begin
                exp_t e;
                #1;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL sb_underflow: got read with empty queue expected queued entry");
                end else begin
                    e = sb_q.pop_front();
                    check_output($sformatf("rd%0d_a_p0", e.id), rd_data_a[31:0],  e.a0);
                    check_output($sformatf("rd%0d_a_p1", e.id), rd_data_a[63:32], e.a1);
                    check_output($sformatf("rd%0d_b_p0", e.id), rd_data_b[31:0],  e.b0);
                    check_output($sformatf("rd%0d_b_p1", e.id), rd_data_b[63:32], e.b1);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_size = SZ_WORD;
        rd_en = 1'b0; rd_addr = '0; clr_req = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_rd_a", rd_data_a[31:0] | rd_data_a[63:32], 32'd0);
        check_output("reset_rd_b", rd_data_b[31:0] | rd_data_b[63:32], 32'd0);
        check_output("reset_busy_a", {31'd0, busy_a}, 32'd1);
        check_output("reset_busy_b", {31'd0, busy_b}, 32'd1);

        rst_n = 1'b1;
        count_busy(1'b0, cnt_a, cnt_b);
        check_output("init_busy_cycles_a", cnt_a, 32'd31);
        check_output("init_busy_cycles_b", cnt_b, 32'd23);
        for (int r = 0; r < 16; r++) rd_pair(5'(r), 5'(31 - r), 0, 0, 0, 0);

        // partial writes merge into existing contents
        wr_word(5'd5, 32'hDEAD_BEEF);
        apply_stimulus(1'b1, 5'd5, 32'hAAAA_AA11, SZ_BYTE, 1'b0, 5'd0, 5'd0, 0, 0, 0, 0);
        rd_pair(5'd5, 5'd5, 32'hDEAD_BE11, 32'hDEAD_BE11, 32'hDEAD_BE11, 32'hDEAD_BE11);
        apply_stimulus(1'b1, 5'd5, 32'hBBBB_2222, SZ_HALF, 1'b0, 5'd0, 5'd0, 0, 0, 0, 0);
        rd_pair(5'd5, 5'd5, 32'hDEAD_2222, 32'hDEAD_2222, 32'hDEAD_2222, 32'hDEAD_2222);

        // r0 is hardwired; r30 and r23 probe the NREGS=24 boundary
        wr_word(5'd0, 32'hFFFF_FFFF);
        rd_pair(5'd0, 5'd0, 0, 0, 0, 0);
        apply_stimulus(1'b1, 5'd0, 32'hFFFF_FFFF, SZ_WORD, 1'b1, 5'd0, 5'd0, 0, 0, 0, 0);
        wr_word(5'd30, 32'hCAFE_F00D);
        rd_pair(5'd30, 5'd5, 32'hCAFE_F00D, 32'hDEAD_2222, 32'd0, 32'hDEAD_2222);
        wr_word(5'd23, 32'h0BAD_C0DE);
        rd_pair(5'd23, 5'd30, 32'h0BAD_C0DE, 32'hCAFE_F00D, 32'h0BAD_C0DE, 32'd0);

        // same-cycle write and read: A forwards, B returns the old value
        wr_word(5'd7, 32'hA5A5_A5A5);
        apply_stimulus(1'b1, 5'd7, 32'h1234_5678, SZ_WORD, 1'b1, 5'd7, 5'd7,
                       32'h1234_5678, 32'h1234_5678, 32'hA5A5_A5A5, 32'hA5A5_A5A5);
        rd_pair(5'd7, 5'd5, 32'h1234_5678, 32'hDEAD_2222, 32'h1234_5678, 32'hDEAD_2222);
        apply_stimulus(1'b1, 5'd7, 32'h0000_0099, SZ_BYTE, 1'b1, 5'd7, 5'd7,
                       32'h1234_5699, 32'h1234_5699, 32'h1234_5678, 32'h1234_5678);
        rd_pair(5'd7, 5'd30, 32'h1234_5699, 32'hCAFE_F00D, 32'h1234_5699, 32'd0);
        apply_stimulus(1'b0, 5'd0, 32'd0, SZ_WORD, 1'b0, 5'd5, 5'd5, 0, 0, 0, 0);
        idle_cycle();
        check_output("hold_a_p0", rd_data_a[31:0], 32'h1234_5699);
        check_output("hold_a_p1", rd_data_a[63:32], 32'hCAFE_F00D);

        // load every register, then request a clear while hammering writes
        for (int r = 1; r < 32; r++) wr_word(5'(r), 32'h100 + 32'(r));
        rd_pair(5'd31, 5'd1, 32'h11F, 32'h101, 32'd0, 32'h101);
        rd_pair(5'd23, 5'd24, 32'h117, 32'h118, 32'h117, 32'd0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b1;
        @(negedge clk);
        count_busy(1'b1, cnt_a, cnt_b);
        check_output("clr_busy_cycles_a", cnt_a, 32'd31);
        check_output("clr_busy_cycles_b", cnt_b, 32'd23);
        for (int r = 0; r < 16; r++) rd_pair(5'(r), 5'(r + 16), 0, 0, 0, 0);

        // reset in the middle of a clear restarts it from index 1
        wr_word(5'd3, 32'h33);
        rd_pair(5'd3, 5'd5, 32'h33, 32'd0, 32'h33, 32'd0);
        @(negedge clk);
        rd_en = 1'b0; wr_en = 1'b0; clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_output("midrst_rd_a", rd_data_a[31:0], 32'd0);
        check_output("midrst_rd_b", rd_data_b[31:0], 32'd0);
        check_output("midrst_busy_a", {31'd0, busy_a}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        count_busy(1'b0, cnt_a, cnt_b);
        check_output("midrst_busy_cycles_a", cnt_a, 32'd31);
        check_output("midrst_busy_cycles_b", cnt_b, 32'd23);
        rd_pair(5'd3, 5'd9, 0, 0, 0, 0);
        rd_pair(5'd10, 5'd31, 0, 0, 0, 0);

        idle_cycle();
        idle_cycle();
        check_output("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
